// File: rtl/tx_frame_streamer.sv
// Streams one Ethernet frame (header, payload from the TX byte buffer, optional zero pad) onto AXI-Stream.
// Optional feature: define MIN_FRAME_PAD_EN to zero-pad short payloads up to a 60-byte frame.
module tx_frame_streamer #(
  parameter logic [47:0] DEST_MAC   = 48'hFF_FF_FF_FF_FF_FF,
  parameter logic [47:0] SRC_MAC    = 48'h5A_01_02_03_04_05,
  parameter int          GAP_CYCLES = 12,
  parameter int          LEN_W      = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] payload_len,
  output logic             busy,
  output logic             frame_done,
  output logic             len_err,
  input  logic             btx_empty,
  input  logic [7:0]       btx_data,
  output logic             btx_rd_en,
  output logic [7:0]       tx_axis_tdata,
  output logic             tx_axis_tvalid,
  output logic             tx_axis_tlast,
  input  logic             tx_axis_tready
);

  localparam int               MAX_LEN = 1500;
  localparam int               GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
`ifdef MIN_FRAME_PAD_EN
  localparam int               MIN_PAY = 46;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_PAY,
    S_GAP
`ifdef MIN_FRAME_PAD_EN
    , S_PAD
`endif
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_pay_cnt;
  logic [LEN_W-1:0] r_req_cnt;
  logic [3:0]       r_hdr_idx;
  logic [GAP_W-1:0] r_gap_cnt;
  logic [7:0]       r_fifo0;
  logic [7:0]       r_fifo1;
  logic [1:0]       r_fcnt;
  logic             r_inflight;
  logic [7:0]       r_tdata;
  logic             r_tvalid;
  logic             r_tlast;
  logic             r_frame_done;
  logic             r_len_err;

  logic             w_adv;
  logic             w_hs;
  logic             w_ld;
  logic [7:0]       w_ld_data;
  logic             w_ld_last;
  logic             w_pop;
  logic             w_accept;
  logic             w_reject;
  logic             w_len_ok;
  logic             w_last_pay;
  logic             w_fetch;
  logic [1:0]       w_held_after;
  logic [15:0]      w_len16;
`ifdef MIN_FRAME_PAD_EN
  logic [LEN_W-1:0] r_pad_cnt;
  logic [LEN_W-1:0] w_pad_total;
  logic             w_pad_need;
`endif

  // Header byte idx of {DA, SA, length}, most significant byte first.
  function automatic logic [7:0] hdr_byte(input logic [3:0] idx, input logic [15:0] len16);
    logic [111:0] v;
    v = {DEST_MAC, SRC_MAC, len16} >> (7'd8 * (7'd13 - 7'(idx)));
    return v[7:0];
  endfunction

  assign w_adv      = !r_tvalid || tx_axis_tready;
  assign w_hs       = r_tvalid && tx_axis_tready;
  assign w_len_ok   = (payload_len != '0) && (32'(payload_len) <= 32'(MAX_LEN));
  assign w_last_pay = (r_pay_cnt == r_len - LEN_ONE);
  assign w_len16    = 16'(r_len);
`ifdef MIN_FRAME_PAD_EN
  assign w_pad_need  = (32'(r_len) < 32'(MIN_PAY));
  assign w_pad_total = LEN_W'(MIN_PAY) - r_len;
`endif

  // Held counts prefetch entries still occupied after this cycle's pop,
  // so in_flight + held never exceeds the two FIFO slots.
  assign w_fetch      = (r_state == S_HDR) || (r_state == S_PAY);
  assign w_held_after = r_fcnt - {1'b0, w_pop};
  assign btx_rd_en    = !rst && w_fetch && !btx_empty && (r_req_cnt < r_len) &&
                        (({1'b0, r_inflight} + w_held_after) < 2'd2);

  assign busy           = (r_state != S_IDLE);
  assign frame_done     = r_frame_done;
  assign len_err        = r_len_err;
  assign tx_axis_tdata  = r_tdata;
  assign tx_axis_tvalid = r_tvalid;
  assign tx_axis_tlast  = r_tlast;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ld        = 1'b0;
    w_ld_data   = 8'h00;
    w_ld_last   = 1'b0;
    w_pop       = 1'b0;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_len_ok) begin
            w_accept    = 1'b1;
            w_ld        = 1'b1;
            w_ld_data   = hdr_byte(4'd0, 16'h0000);
            w_state_nxt = S_HDR;
          end else begin
            w_reject = 1'b1;
          end
        end
      end
      S_HDR: begin
        if (w_adv) begin
          w_ld      = 1'b1;
          w_ld_data = hdr_byte(r_hdr_idx, w_len16);
          if (r_hdr_idx == 4'd13) w_state_nxt = S_PAY;
        end
      end
      S_PAY: begin
        if (w_hs && r_tlast) begin
          w_state_nxt = S_GAP;
        end else if (w_adv && (r_fcnt != 2'd0) && (r_pay_cnt != r_len)) begin
          w_ld      = 1'b1;
          w_pop     = 1'b1;
          w_ld_data = r_fifo0;
`ifdef MIN_FRAME_PAD_EN
          if (w_last_pay && w_pad_need) w_state_nxt = S_PAD;
          else                          w_ld_last   = w_last_pay;
`else
          w_ld_last = w_last_pay;
`endif
        end
      end
`ifdef MIN_FRAME_PAD_EN
      S_PAD: begin
        if (w_hs && r_tlast) begin
          w_state_nxt = S_GAP;
        end else if (w_adv && (r_pad_cnt != w_pad_total)) begin
          w_ld      = 1'b1;
          w_ld_data = 8'h00;
          w_ld_last = (r_pad_cnt == w_pad_total - LEN_ONE);
        end
      end
`endif
      S_GAP: begin
        if (r_gap_cnt == GAP_W'(GAP_CYCLES - 1)) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_len     <= '0;
      r_hdr_idx <= '0;
      r_pay_cnt <= '0;
      r_req_cnt <= '0;
      r_gap_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_len     <= payload_len;
        r_hdr_idx <= 4'd1;
        r_pay_cnt <= '0;
        r_req_cnt <= '0;
      end else begin
        if ((r_state == S_HDR) && w_ld) r_hdr_idx <= r_hdr_idx + 4'd1;
        if (w_pop)                      r_pay_cnt <= r_pay_cnt + LEN_ONE;
        if (btx_rd_en)                  r_req_cnt <= r_req_cnt + LEN_ONE;
      end
      r_gap_cnt <= (r_state == S_GAP) ? r_gap_cnt + GAP_W'(1) : '0;
    end
  end

`ifdef MIN_FRAME_PAD_EN
  always_ff @(posedge clk) begin
    if (rst || w_accept)            r_pad_cnt <= '0;
    else if ((r_state == S_PAD) && w_ld) r_pad_cnt <= r_pad_cnt + LEN_ONE;
  end
`endif

  // Prefetch FIFO: buffer data lands one cycle after the pop request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fifo0    <= '0;
      r_fifo1    <= '0;
      r_fcnt     <= '0;
      r_inflight <= 1'b0;
    end else begin
      case ({r_inflight, w_pop})
        2'b10: begin
          if (r_fcnt == 2'd0) r_fifo0 <= btx_data;
          else                r_fifo1 <= btx_data;
          r_fcnt <= r_fcnt + 2'd1;
        end
        2'b01: begin
          r_fifo0 <= r_fifo1;
          r_fcnt  <= r_fcnt - 2'd1;
        end
        2'b11: begin
          if (r_fcnt == 2'd1) begin
            r_fifo0 <= btx_data;
          end else begin
            r_fifo0 <= r_fifo1;
            r_fifo1 <= btx_data;
          end
        end
        default: ;
      endcase
      r_inflight <= btx_rd_en;
    end
  end

  // Output register: holds its beat until the MAC accepts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tdata      <= '0;
      r_tvalid     <= 1'b0;
      r_tlast      <= 1'b0;
      r_frame_done <= 1'b0;
      r_len_err    <= 1'b0;
    end else begin
      if (w_adv) begin
        r_tvalid <= w_ld;
        r_tlast  <= w_ld_last;
        if (w_ld) r_tdata <= w_ld_data;
      end
      r_frame_done <= w_hs && r_tlast;
      r_len_err    <= w_reject;
    end
  end

endmodule
